wb_ram_arbiter: RTL and testbench
=================================

Name: wb_ram_arbiter

Overview:
- Round-robin Wishbone B3 arbiter that shares the single main-RAM slave port (wb_ram) among NUM_MASTERS bus masters.
- Default masters: 0 = CPU instruction bus, 1 = CPU data bus, 2 = adv_debug_sys debug master.
- Holds a grant for the whole cycle (cyc_i high), so registered-feedback bursts (cti/bte) are never split.
- Includes a stall watchdog that returns err to the granted master if the slave never terminates a strobe.

Parameters:
- NUM_MASTERS, 3, number of requesting masters (2..8).
- AW, 32, address width.
- DW, 32, data width; sel width is DW/8.
- TIMEOUT, 255, cycles of unanswered strobe before a watchdog err; 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- m_adr_i  in  NUM_MASTERS*AW  master addresses, packed, master 0 in LSBs.
- m_dat_i  in  NUM_MASTERS*DW  master write data.
- m_sel_i  in  NUM_MASTERS*DW/8  byte selects.
- m_we_i  in  NUM_MASTERS  write enables.
- m_cyc_i  in  NUM_MASTERS  cycle requests.
- m_stb_i  in  NUM_MASTERS  strobes.
- m_cti_i  in  NUM_MASTERS*3  cycle type identifiers.
- m_bte_i  in  NUM_MASTERS*2  burst type extensions.
- m_dat_o  out  DW  read data; s_dat_i broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master ack.
- m_err_o  out  NUM_MASTERS  per-master err, including watchdog err.
- m_rty_o  out  NUM_MASTERS  per-master rty.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_sel_o  out  DW/8  slave byte selects.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_cti_o  out  3  slave cycle type.
- s_bte_o  out  2  slave burst type.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave err.
- s_rty_i  in  1  slave rty.
- grant_o  out  NUM_MASTERS  one-hot registered grant; all zero when idle.

Behaviour:
- Reset: while wb_rst_n_i is low, all state clears immediately (asynchronously).
  - State = IDLE; grant_o = 0; watchdog counter = 0; last pointer = NUM_MASTERS-1, so master 0 wins first.
  - All s_* outputs and m_ack_o/m_err_o/m_rty_o are 0. m_dat_o follows s_dat_i.
  - Reset asserted mid-burst abandons the transfer; no ack is forwarded from the cycle reset is asserted.
- FSM, two states:
  - IDLE: at a clock edge with any m_cyc_i high, select the first requester searching upward from last+1 modulo NUM_MASTERS. Then grant_o <= one-hot(sel), last <= sel, state <= GRANT.
  - GRANT: when the granted m_cyc_i is sampled low, grant_o <= 0 and state <= IDLE. Otherwise hold the grant, regardless of other requests or cti.
- Latency:
  - A request sampled at edge N drives s_cyc_o in cycle N+1.
  - After a release, one IDLE cycle occurs before the next grant. Back-to-back cycles from different masters are therefore separated by at least 1 dead cycle.
- Muxing (combinational from grant_o):
  - s_adr/dat/sel/we/cti/bte_o = the granted master's inputs.
  - s_cyc_o = granted m_cyc_i.
  - s_stb_o = granted m_stb_i & m_cyc_i.
  - With no grant: s_cyc_o = s_stb_o = s_we_o = 0, and the other s_* outputs are 0.
- Responses:
  - m_ack_o[i] = grant_o[i] & s_ack_i.
  - m_rty_o[i] = grant_o[i] & s_rty_i.
  - m_err_o[i] = grant_o[i] & (s_err_i | wd_err).
  - Non-granted masters never see any response.
- Watchdog:
  - The counter increments each cycle in GRANT with s_stb_o=1 and no s_ack_i/s_err_i/s_rty_i.
  - It clears on any slave response, on s_stb_o=0, or on leaving GRANT.
  - When the counter equals TIMEOUT, wd_err is high for exactly that one cycle and the counter clears.
  - The grant is not revoked; the master is expected to drop cyc.
  - The counter is 8 bits wide for the default; its width is clog2(TIMEOUT+1) and it saturates, with no wrap before the compare.
- Simultaneous events: a slave response and a watchdog compare in the same cycle produce only the slave response, and the counter clears.
- Requests that arrive during a GRANT are queued implicitly; they are not lost while cyc remains held.
- A master whose cyc drops without being granted is simply skipped.

Test Plan:
- Reset, then m_cyc_i=3'b001 asserted for a 4-beat incrementing burst (cti 010,010,010,111) with slave ack each cycle -> grant_o=001 one cycle after cyc; 4 m_ack_o[0] pulses; s_cti_o matches beat-by-beat; grant_o=000 one cycle after cyc drops.
- m_cyc_i=3'b111 continuously, each master doing single-beat cycles -> grant order 0,1,2,0,1,2, with one idle cycle between grants.
- Master 1 in an 8-beat burst while master 0 and master 2 assert cyc at beat 2 -> no grant change until master 1 drops cyc; next grant goes to master 2 (last=1, so search starts at 2).
- TIMEOUT=255, master 2 strobes with the slave never responding -> m_err_o[2] is high exactly in the 256th strobe cycle, a single-cycle pulse; m_err_o[0] and m_err_o[1] stay 0.
- wb_rst_n_i driven low mid-burst for master 0 (asynchronous, between clock edges) -> s_cyc_o, s_stb_o and grant_o go to 0 immediately; after release, master 0 is granted first again.
- Slave s_err_i and s_rty_i pulses during master 1 cycles -> routed only to m_err_o[1] and m_rty_o[1]; m_dat_o equals s_dat_i (e.g. 32'hDEADBEEF) in the same cycle as ack.

Source files
------------

// File: rtl/wb_ram_arbiter.sv
// ============================================================================
// Module   : wb_ram_arbiter
// Purpose  : Round-robin Wishbone B3 arbiter sharing one RAM slave port among
//            NUM_MASTERS masters, with an unanswered-strobe watchdog.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_ram_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_n_i,

    input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0]   m_sel_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS-1:0]        m_cyc_i,
    input  logic [NUM_MASTERS-1:0]        m_stb_i,
    input  logic [NUM_MASTERS*3-1:0]      m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]      m_bte_i,
    output logic [DW-1:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    output logic [NUM_MASTERS-1:0]        m_rty_o,

    output logic [AW-1:0]                 s_adr_o,
    output logic [DW-1:0]                 s_dat_o,
    output logic [DW/8-1:0]               s_sel_o,
    output logic                          s_we_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic [2:0]                    s_cti_o,
    output logic [1:0]                    s_bte_o,
    input  logic [DW-1:0]                 s_dat_i,
    input  logic                          s_ack_i,
    input  logic                          s_err_i,
    input  logic                          s_rty_i,

    output logic [NUM_MASTERS-1:0]        grant_o
);

    localparam int IW    = $clog2(NUM_MASTERS);
    localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WD_EN = (TIMEOUT > 0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [IW-1:0]          r_last;
    logic [IW-1:0]          w_last_nxt;
    logic [IW-1:0]          w_sel;
    logic [IW-1:0]          w_cand;
    logic                   w_found;
    logic [CW-1:0]          r_wd_cnt;
    logic [CW-1:0]          w_wd_cnt_nxt;
    logic                   w_wd_err;
    logic                   w_resp;

    // Round-robin search: first requester strictly after the last winner.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last;
        w_cand  = r_last;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_cand = IW'((int'(r_last) + k) % NUM_MASTERS);
            if (!w_found && m_cyc_i[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        w_grant_nxt[i] = (w_sel == IW'(i));
                    end
                    w_last_nxt  = w_sel;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // The grant spans the whole cyc, so bursts are never split.
                if (!s_cyc_o) begin
                    w_grant_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_last   <= IW'(NUM_MASTERS - 1);
            r_wd_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_last   <= w_last_nxt;
            r_wd_cnt <= w_wd_cnt_nxt;
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) begin
                s_adr_o = m_adr_i[i*AW +: AW];
                s_dat_o = m_dat_i[i*DW +: DW];
                s_sel_o = m_sel_i[i*(DW/8) +: (DW/8)];
                s_we_o  = m_we_i[i];
                s_cyc_o = m_cyc_i[i];
                s_stb_o = m_stb_i[i] & m_cyc_i[i];
                s_cti_o = m_cti_i[i*3 +: 3];
                s_bte_o = m_bte_i[i*2 +: 2];
            end
        end
    end

    assign w_resp = s_ack_i | s_err_i | s_rty_i;

    // A real slave response always wins over a coincident watchdog expiry.
    always_comb begin
        w_wd_err     = WD_EN && (r_state == ST_GRANT) && s_stb_o && !w_resp &&
                       (r_wd_cnt == CW'(TIMEOUT));
        w_wd_cnt_nxt = r_wd_cnt;
        if ((r_state != ST_GRANT) || !s_stb_o || w_resp || w_wd_err) begin
            w_wd_cnt_nxt = '0;
        end else if (r_wd_cnt != {CW{1'b1}}) begin
            w_wd_cnt_nxt = r_wd_cnt + 1'b1;
        end
    end

    assign m_dat_o = s_dat_i;
    assign m_ack_o = r_grant & {NUM_MASTERS{s_ack_i}};
    assign m_rty_o = r_grant & {NUM_MASTERS{s_rty_i}};
    assign m_err_o = r_grant & {NUM_MASTERS{s_err_i | w_wd_err}};
    assign grant_o = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_wb_ram_arbiter.sv
// ============================================================================
// Module   : tb_wb_ram_arbiter
// Purpose  : Self-checking bench for wb_ram_arbiter against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_wb_ram_arbiter;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 255;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NM*AW-1:0]  m_adr = '0;
    logic [NM*DW-1:0]  m_dat = '0;
    logic [NM*SW-1:0]  m_sel = '0;
    logic [NM-1:0]     m_we  = '0;
    logic [NM-1:0]     m_cyc = '0;
    logic [NM-1:0]     m_stb = '0;
    logic [NM*3-1:0]   m_cti = '0;
    logic [NM*2-1:0]   m_bte = '0;
    logic [DW-1:0]     s_dat = '0;
    logic              s_ack = 1'b0;
    logic              s_err = 1'b0;
    logic              s_rty = 1'b0;

    logic [DW-1:0]     m_dat_o;
    logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o, grant_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]        s_cti_o;
    logic [1:0]        s_bte_o;

    wb_ram_arbiter #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .m_adr_i    (m_adr),
        .m_dat_i    (m_dat),
        .m_sel_i    (m_sel),
        .m_we_i     (m_we),
        .m_cyc_i    (m_cyc),
        .m_stb_i    (m_stb),
        .m_cti_i    (m_cti),
        .m_bte_i    (m_bte),
        .m_dat_o    (m_dat_o),
        .m_ack_o    (m_ack_o),
        .m_err_o    (m_err_o),
        .m_rty_o    (m_rty_o),
        .s_adr_o    (s_adr_o),
        .s_dat_o    (s_dat_o),
        .s_sel_o    (s_sel_o),
        .s_we_o     (s_we_o),
        .s_cyc_o    (s_cyc_o),
        .s_stb_o    (s_stb_o),
        .s_cti_o    (s_cti_o),
        .s_bte_o    (s_bte_o),
        .s_dat_i    (s_dat),
        .s_ack_i    (s_ack),
        .s_err_i    (s_err),
        .s_rty_i    (s_rty),
        .grant_o    (grant_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: current owner (-1 = nobody), last winner, and the
    // length of the current run of unanswered strobe cycles.
    int owner = -1;
    int last  = NM - 1;
    int wd    = 0;

    logic [NM-1:0] ob_grant, ob_ack, ob_err, ob_rty;
    logic          ob_stb;
    logic [DW-1:0] ob_dat;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [NM-1:0] v);
        int r = -1;
        for (int i = 0; i < NM; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic owner_strobing();
        return (owner >= 0) && m_cyc[owner] && m_stb[owner];
    endfunction

    task automatic check_outputs();
        logic [NM-1:0] eg;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [SW-1:0] es;
        logic [2:0]    ecti;
        logic [1:0]    ebte;
        logic          ewe, ecyc, estb, ewd;
        eg = '0; ea = '0; ed = '0; es = '0; ecti = '0; ebte = '0;
        ewe = 1'b0; ecyc = 1'b0; estb = 1'b0;
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            ea   = m_adr[owner*AW +: AW];
            ed   = m_dat[owner*DW +: DW];
            es   = m_sel[owner*SW +: SW];
            ewe  = m_we[owner];
            ecyc = m_cyc[owner];
            estb = m_cyc[owner] & m_stb[owner];
            ecti = m_cti[owner*3 +: 3];
            ebte = m_bte[owner*2 +: 2];
        end
        ewd = (owner >= 0) && estb && !(s_ack || s_err || s_rty) && (wd == TO);
        check_val("grant", grant_o, eg);
        check_val("s_adr", s_adr_o, ea);
        check_val("s_dat", s_dat_o, ed);
        check_val("s_sel", s_sel_o, es);
        check_val("s_we", s_we_o, ewe);
        check_val("s_cyc", s_cyc_o, ecyc);
        check_val("s_stb", s_stb_o, estb);
        check_val("s_cti", s_cti_o, ecti);
        check_val("s_bte", s_bte_o, ebte);
        check_val("m_dat", m_dat_o, s_dat);
        check_val("m_ack", m_ack_o, s_ack ? eg : '0);
        check_val("m_rty", m_rty_o, s_rty ? eg : '0);
        check_val("m_err", m_err_o, (s_err || ewd) ? eg : '0);
    endtask

    task automatic model_edge();
        bit found;
        int c;
        if (!rst_n) begin
            owner = -1; last = NM - 1; wd = 0;
            return;
        end
        if (owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= NM; k++) begin
                c = (last + k) % NM;
                if (!found && m_cyc[c]) begin
                    found = 1'b1; owner = c; last = c;
                end
            end
        end else begin
            if (!owner_strobing() || s_ack || s_err || s_rty || wd == TO) wd = 0;
            else wd++;
            if (!m_cyc[owner]) begin
                owner = -1; wd = 0;
            end
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising
    // edge, then hand control back 1ns later for the next input change.
    task automatic step();
        @(negedge clk);
        check_outputs();
        ob_grant = grant_o; ob_ack = m_ack_o; ob_err = m_err_o;
        ob_rty = m_rty_o; ob_stb = s_stb_o; ob_dat = m_dat_o;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        rst_n = 1'b0; owner = -1; last = NM - 1; wd = 0;
        step(); step();
        rst_n = 1'b1;
    endtask

    initial begin : main
        int acks, first_n, prev_oh, scnt, errs, err_at, other, drop;
        int q[$];
        int job[NM];
        bit fin[NM];
        int codes[8];
        int e1, r1, a1;

        // --- reset and a 4-beat incrementing burst from master 0 ---
        do_reset();
        m_adr[0 +: AW] = 32'h0000_1000;
        m_cyc = 3'b001; m_stb = 3'b001; m_cti[2:0] = 3'b010;
        acks = 0; first_n = -1;
        for (int n = 0; n < 12; n++) begin
            s_ack = owner_strobing();
            step();
            if (first_n < 0 && ob_grant != '0) first_n = n;
            if (ob_ack[0]) begin
                acks++;
                m_adr[0 +: AW] = m_adr[0 +: AW] + 32'd4;
                if (acks == 3) m_cti[2:0] = 3'b111;
                if (acks == 4) begin m_cyc = '0; m_stb = '0; m_cti[2:0] = 3'b000; end
            end
        end
        check_val("burst_grant_latency", first_n, 1);
        check_val("burst_ack_count", acks, 4);

        // --- all three masters requesting single beats: 0,1,2,0,1,2 ---
        do_reset();
        q.delete(); prev_oh = 0; drop = -1;
        for (int n = 0; n < 40; n++) begin
            m_cyc = '1; m_stb = '1;
            if (drop >= 0) begin m_cyc[drop] = 1'b0; m_stb[drop] = 1'b0; end
            drop = -1;
            s_ack = owner_strobing();
            if (s_ack) drop = owner;
            step();
            if (ob_grant != '0 && prev_oh == 0) q.push_back(oh_idx(ob_grant));
            prev_oh = (ob_grant != '0) ? 1 : 0;
        end
        for (int i = 0; i < 6; i++) begin
            check_val("rr_order", (q.size() > i) ? q[i] : -1, i % NM);
        end

        // --- master 1 burst of 8, masters 0 and 2 join at beat 2 ---
        do_reset();
        m_cyc = 3'b010; m_stb = 3'b010; m_cti[5:3] = 3'b010;
        acks = 0; q.delete(); prev_oh = 0;
        for (int n = 0; n < 30; n++) begin
            s_ack = (owner == 1) && owner_strobing();
            step();
            if (ob_grant != '0 && prev_oh == 0) q.push_back(oh_idx(ob_grant));
            prev_oh = (ob_grant != '0) ? 1 : 0;
            if (ob_ack[1]) begin
                acks++;
                if (acks == 2) begin m_cyc = 3'b111; m_stb = 3'b111; end
                if (acks == 8) begin m_cyc[1] = 1'b0; m_stb[1] = 1'b0; end
            end
        end
        check_val("burst8_first", (q.size() > 0) ? q[0] : -1, 1);
        check_val("burst8_next", (q.size() > 1) ? q[1] : -1, 2);
        check_val("burst8_acks", acks, 8);

        // --- watchdog: master 2 strobes into a silent slave ---
        do_reset();
        m_cyc = 3'b100; m_stb = 3'b100;
        scnt = 0; errs = 0; err_at = -1; other = 0;
        for (int n = 0; n < 300; n++) begin
            step();
            if (ob_stb) scnt++;
            if (ob_err[2]) begin errs++; err_at = scnt; end
            if (ob_err[1:0] != '0) other++;
        end
        check_val("wd_err_cycle", err_at, 256);
        check_val("wd_err_pulses", errs, 1);
        check_val("wd_other_err", other, 0);

        // --- asynchronous reset in the middle of a master 0 burst ---
        do_reset();
        m_cyc = 3'b001; m_stb = 3'b001;
        for (int n = 0; n < 4; n++) begin
            s_ack = owner_strobing();
            step();
        end
        s_ack = 1'b0;
        #1;
        rst_n = 1'b0; owner = -1; last = NM - 1; wd = 0;
        #1;
        check_val("arst_grant", grant_o, 0);
        check_val("arst_cyc", s_cyc_o, 0);
        check_val("arst_stb", s_stb_o, 0);
        check_val("arst_ack", m_ack_o, 0);
        m_cyc = 3'b011; m_stb = 3'b011;
        step();
        rst_n = 1'b1;
        first_n = -1;
        for (int n = 0; n < 4; n++) begin
            step();
            if (first_n < 0 && ob_grant != '0) first_n = oh_idx(ob_grant);
        end
        check_val("arst_regrant", first_n, 0);

        // --- err / rty / ack routing for master 1 ---
        do_reset();
        codes = '{2, 0, 2, 3, 0, 3, 1, 1};
        m_cyc = 3'b010; m_stb = 3'b010; s_dat = 32'hDEAD_BEEF;
        e1 = 0; r1 = 0; a1 = 0; other = 0;
        for (int n = 0; n < 8; n++) begin
            s_ack = (codes[n] == 1); s_err = (codes[n] == 2); s_rty = (codes[n] == 3);
            step();
            if (ob_err[1]) e1++;
            if (ob_rty[1]) r1++;
            if (ob_ack[1]) begin
                a1++;
                check_val("ack_rdata", ob_dat, 32'hDEAD_BEEF);
            end
            if ((ob_err[0] | ob_err[2] | ob_rty[0] | ob_rty[2] | ob_ack[0] | ob_ack[2]) != 1'b0) other++;
        end
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        check_val("route_err1", e1, 1);
        check_val("route_rty1", r1, 2);
        check_val("route_ack1", a1, 2);
        check_val("route_others", other, 0);

        // --- randomized traffic against the model ---
        do_reset();
        for (int i = 0; i < NM; i++) job[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NM; i++) begin
                m_adr[i*AW +: AW] = $urandom;
                m_dat[i*DW +: DW] = $urandom;
                m_sel[i*SW +: SW] = SW'($urandom);
                m_we[i]           = 1'($urandom);
                m_cti[i*3 +: 3]   = 3'($urandom);
                m_bte[i*2 +: 2]   = 2'($urandom);
                m_stb[i]          = m_cyc[i] ? ($urandom_range(0, 3) != 0) : 1'($urandom);
            end
            s_dat = $urandom;
            s_ack = ($urandom_range(0, 9) < 6);
            s_err = ($urandom_range(0, 19) == 0);
            s_rty = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < NM; i++)
                fin[i] = (owner == i) && owner_strobing() && (s_ack || s_err || s_rty);
            step();
            for (int i = 0; i < NM; i++) begin
                if (m_cyc[i]) begin
                    if (fin[i]) job[i] = s_ack ? job[i] - 1 : 0;
                    else if (owner != i && $urandom_range(0, 49) == 0) job[i] = 0;
                    if (job[i] <= 0) begin job[i] = 0; m_cyc[i] = 1'b0; end
                end else if ($urandom_range(0, 3) == 0) begin
                    job[i] = $urandom_range(1, 5);
                    m_cyc[i] = 1'b1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
